// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source synchronisers, edge/level pending capture,
// CSR-mapped PEND/EN/MODE/PRIO registers and a registered request to the trap unit.
// Optional macro IRQ_CTRL_PRIO_EN adds a 2-bit priority per source (3 = highest);
// without it the lowest pending-and-enabled index wins.
module irq_ctrl #(
   parameter int unsigned NUM_IRQ   = 10,
   parameter int unsigned BASE_CODE = 16,
   parameter logic [11:0] CSR_PEND  = 12'h7C0,
   parameter logic [11:0] CSR_EN    = 12'h7C1,
   parameter logic [11:0] CSR_MODE  = 12'h7C2,
   parameter logic [11:0] CSR_PRIO  = 12'h7C3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic               csr_rd_en,
   input  logic               csr_wr_en,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wr_data,
   output logic [31:0]        csr_rd_data,
   input  logic               global_mie,
   output logic               irq_valid,
   output logic [3:0]         irq_id,
   output logic [31:0]        irq_cause,
   input  logic               irq_ack
);

   // Synchroniser chain and edge history
   logic [NUM_IRQ-1:0] sync1_q, sync2_q, hist_q;

   // Architectural registers
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] en_q, en_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
`ifdef IRQ_CTRL_PRIO_EN
   logic [2*NUM_IRQ-1:0] prio_q, prio_d;
   logic [1:0]           best_prio;
`endif

   // Request pipeline
   logic       irq_valid_q, irq_valid_d;
   logic [3:0] irq_id_q, irq_id_d;

   // Helpers
   logic               ack_eff;
   logic [NUM_IRQ-1:0] edge_det;
   logic [NUM_IRQ-1:0] ack_hit;
   logic [NUM_IRQ-1:0] csr_clr;
   logic [NUM_IRQ-1:0] cand;
   logic [3:0]         winner;
   logic               found;
   logic               take;
   logic               wr_pend, wr_en, wr_mode;
   logic               unused_wr_bits;

   // Write data bits beyond the implemented sources are intentionally dropped
   assign unused_wr_bits = ^csr_wr_data[31:NUM_IRQ];

   assign wr_pend = csr_wr_en && (csr_addr == CSR_PEND);
   assign wr_en   = csr_wr_en && (csr_addr == CSR_EN);
   assign wr_mode = csr_wr_en && (csr_addr == CSR_MODE);

   // An ack only counts while a request is actually being presented
   assign ack_eff = irq_ack && irq_valid_q;

   assign edge_det = sync2_q & ~hist_q;
   assign cand     = pend_q & en_q;

   // Synchroniser, history and register state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         hist_q      <= '0;
         pend_q      <= '0;
         en_q        <= '0;
         mode_q      <= '1;
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         sync1_q     <= irq_src;
         sync2_q     <= sync1_q;
         hist_q      <= sync2_q;
         pend_q      <= pend_d;
         en_q        <= en_d;
         mode_q      <= mode_d;
         irq_valid_q <= irq_valid_d;
         irq_id_q    <= irq_id_d;
      end
   end

`ifdef IRQ_CTRL_PRIO_EN
   // Priority register state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q <= '0;
      end else begin
         prio_q <= prio_d;
      end
   end
`endif

   // Pending next state: edge bits set on a new edge (set wins over clears),
   // level bits simply follow the synchronised line
   always_comb begin
      ack_hit = '0;
      csr_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         ack_hit[i] = ack_eff && (irq_id_q == 4'(i));
      end
      if (wr_pend) begin
         csr_clr = ~csr_wr_data[NUM_IRQ-1:0];
      end
      pend_d = (mode_q & (edge_det | (pend_q & ~(ack_hit | csr_clr))))
             | (~mode_q & sync2_q);
   end

   // Enable / mode / priority register updates
   always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      if (wr_en) begin
         en_d = csr_wr_data[NUM_IRQ-1:0];
      end
      if (wr_mode) begin
         mode_d = csr_wr_data[NUM_IRQ-1:0];
      end
`ifdef IRQ_CTRL_PRIO_EN
      prio_d = prio_q;
      if (csr_wr_en && (csr_addr == CSR_PRIO)) begin
         prio_d = csr_wr_data[2*NUM_IRQ-1:0];
      end
`endif
   end

   // Arbitration: strictly-greater comparison keeps ties on the lowest index
   always_comb begin
      winner = '0;
      found  = 1'b0;
      take   = 1'b0;
`ifdef IRQ_CTRL_PRIO_EN
      best_prio = '0;
`endif
      for (int i = 0; i < NUM_IRQ; i++) begin
`ifdef IRQ_CTRL_PRIO_EN
         take = cand[i] && (!found || (prio_q[2*i +: 2] > best_prio));
`else
         take = cand[i] && !found;
`endif
         if (take) begin
            found  = 1'b1;
            winner = 4'(i);
`ifdef IRQ_CTRL_PRIO_EN
            best_prio = prio_q[2*i +: 2];
`endif
         end
      end
   end

   // Request pipeline: one bubble after an accepted ack so arbitration sees cleared PEND
   always_comb begin
      irq_valid_d = global_mie && (|cand) && !ack_eff;
      irq_id_d    = winner;
   end

   // CSR read mux, zero-extended, 0 when not reading or address unknown
   always_comb begin
      csr_rd_data = '0;
      if (csr_rd_en) begin
         if (csr_addr == CSR_PEND) begin
            csr_rd_data = 32'(pend_q);
         end else if (csr_addr == CSR_EN) begin
            csr_rd_data = 32'(en_q);
         end else if (csr_addr == CSR_MODE) begin
            csr_rd_data = 32'(mode_q);
`ifdef IRQ_CTRL_PRIO_EN
         end else if (csr_addr == CSR_PRIO) begin
            csr_rd_data = 32'(prio_q);
`endif
         end
      end
   end

   assign irq_valid = irq_valid_q;
   assign irq_id    = irq_id_q;
   // Held at the base code while reset is asserted, independent of register contents
   assign irq_cause = rst_n ? {1'b1, 31'(BASE_CODE + 32'(irq_id_q))}
                            : {1'b1, 31'(BASE_CODE)};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default parameters).
module tb_irq_ctrl;

   localparam logic [11:0] A_PEND = 12'h7C0;
   localparam logic [11:0] A_EN   = 12'h7C1;
   localparam logic [11:0] A_MODE = 12'h7C2;
   localparam logic [11:0] A_PRIO = 12'h7C3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  irq_src;
   logic        csr_rd_en, csr_wr_en;
   logic [11:0] csr_addr;
   logic [31:0] csr_wr_data, csr_rd_data;
   logic        global_mie;
   logic        irq_valid;
   logic [3:0]  irq_id;
   logic [31:0] irq_cause;
   logic        irq_ack;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] rd;

   irq_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_src     (irq_src),
      .csr_rd_en   (csr_rd_en),
      .csr_wr_en   (csr_wr_en),
      .csr_addr    (csr_addr),
      .csr_wr_data (csr_wr_data),
      .csr_rd_data (csr_rd_data),
      .global_mie  (global_mie),
      .irq_valid   (irq_valid),
      .irq_id      (irq_id),
      .irq_cause   (irq_cause),
      .irq_ack     (irq_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_wr_en   = 1'b1;
      csr_addr    = a;
      csr_wr_data = d;
      tick();
      csr_wr_en   = 1'b0;
   endtask

   task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
      csr_rd_en = 1'b1;
      csr_addr  = a;
      #1;
      d = csr_rd_data;
      csr_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total_cnt++;
      if (irq_cause !== 32'h8000_0010) $display("FAIL rst_cause: got %h expected %h", irq_cause, 32'h8000_0010);
      else pass_cnt++;
      total_cnt++;
      if (irq_valid !== 1'b0 || irq_id !== 4'd0) $display("FAIL rst_valid_id: got %b/%0d expected 0/0", irq_valid, irq_id);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL rst_pend: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_read(A_EN, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL rst_en: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_read(A_MODE, rd);
      total_cnt++;
      if (rd !== 32'h3FF) $display("FAIL rst_mode: got %h expected %h", rd, 32'h3FF);
      else pass_cnt++;
      csr_read(A_PRIO, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL rst_prio: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_read(12'h7C4, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL rd_unknown_addr: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_addr  = A_MODE;
      csr_rd_en = 1'b0;
      #1;
      total_cnt++;
      if (csr_rd_data !== 32'h0) $display("FAIL rd_without_en: got %h expected %h", csr_rd_data, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_edge();
      csr_write(A_EN, 32'h3FF);
      global_mie = 1'b1;
      irq_src[3] = 1'b1;
      tick();
      irq_src[3] = 1'b0;
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL edge_pend_early: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h008) $display("FAIL edge_pend: got %h expected %h", rd, 32'h008);
      else pass_cnt++;
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL edge_valid_early: got %b expected 0", irq_valid);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd3 || irq_cause !== 32'h8000_0013)
         $display("FAIL edge_req: got %b/%0d/%h expected 1/3/80000013", irq_valid, irq_id, irq_cause);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL edge_after_ack: got %b expected 0", irq_valid);
      else pass_cnt++;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL edge_pend_cleared: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL edge_idle: got %b expected 0", irq_valid);
      else pass_cnt++;
   endtask

   task automatic test_csr_and_ack_ignore();
      csr_write(A_EN, 32'h0);
      irq_src[0] = 1'b1;
      tick();
      irq_src[0] = 1'b0;
      tick();
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h001) $display("FAIL dis_pend: got %h expected %h", rd, 32'h001);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL dis_valid: got %b expected 0", irq_valid);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h001) $display("FAIL ack_ignored: got %h expected %h", rd, 32'h001);
      else pass_cnt++;
      global_mie = 1'b0;
      csr_write(A_EN, 32'h001);
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL mie_gate: got %b expected 0", irq_valid);
      else pass_cnt++;
      global_mie = 1'b1;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd0) $display("FAIL mie_on: got %b/%0d expected 1/0", irq_valid, irq_id);
      else pass_cnt++;
      csr_write(A_PEND, 32'h3FE);
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL pend_csr_clear: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_write(A_PEND, 32'h3FF);
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL pend_write_one: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_write(A_EN, 32'hFFFF_FFFF);
      csr_read(A_EN, rd);
      total_cnt++;
      if (rd !== 32'h3FF) $display("FAIL en_upper_bits: got %h expected %h", rd, 32'h3FF);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL valid_after_clear: got %b expected 0", irq_valid);
      else pass_cnt++;
   endtask

   task automatic test_arbitration();
      csr_write(A_EN, 32'h024);
      irq_src = 10'h024;
      tick();
      irq_src = 10'h000;
      tick();
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h024) $display("FAIL arb_pend: got %h expected %h", rd, 32'h024);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd2) $display("FAIL arb_first: got %b/%0d expected 1/2", irq_valid, irq_id);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL arb_bubble: got %b expected 0", irq_valid);
      else pass_cnt++;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h020) $display("FAIL arb_pend_after_ack: got %h expected %h", rd, 32'h020);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd5 || irq_cause !== 32'h8000_0015)
         $display("FAIL arb_second: got %b/%0d/%h expected 1/5/80000015", irq_valid, irq_id, irq_cause);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL arb_drained: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_level();
      csr_write(A_EN, 32'h002);
      csr_write(A_MODE, 32'h3FD);
      csr_read(A_MODE, rd);
      total_cnt++;
      if (rd !== 32'h3FD) $display("FAIL lvl_mode: got %h expected %h", rd, 32'h3FD);
      else pass_cnt++;
      irq_src[1] = 1'b1;
      tick();
      tick();
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h002) $display("FAIL lvl_pend: got %h expected %h", rd, 32'h002);
      else pass_cnt++;
      csr_write(A_PEND, 32'h0);
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h002) $display("FAIL lvl_csr_clear_ignored: got %h expected %h", rd, 32'h002);
      else pass_cnt++;
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd1) $display("FAIL lvl_req: got %b/%0d expected 1/1", irq_valid, irq_id);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL lvl_bubble: got %b expected 0", irq_valid);
      else pass_cnt++;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h002) $display("FAIL lvl_pend_after_ack: got %h expected %h", rd, 32'h002);
      else pass_cnt++;
      irq_src[1] = 1'b0;
      tick();
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h002) $display("FAIL lvl_pend_hold: got %h expected %h", rd, 32'h002);
      else pass_cnt++;
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL lvl_pend_drop: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_write(A_MODE, 32'h3FF);
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL lvl_idle: got %b expected 0", irq_valid);
      else pass_cnt++;
   endtask

   task automatic test_set_priority();
      csr_write(A_EN, 32'h010);
      irq_src[4] = 1'b1;
      tick();
      irq_src[4] = 1'b0;
      tick();
      irq_src[4] = 1'b1;   // second rise lands its edge on the ack cycle
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h010) $display("FAIL setp_pend: got %h expected %h", rd, 32'h010);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd4) $display("FAIL setp_req: got %b/%0d expected 1/4", irq_valid, irq_id);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      irq_src[4] = 1'b0;
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL setp_bubble: got %b expected 0", irq_valid);
      else pass_cnt++;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h010) $display("FAIL setp_pend_kept: got %h expected %h", rd, 32'h010);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== 4'd4) $display("FAIL setp_rereq: got %b/%0d expected 1/4", irq_valid, irq_id);
      else pass_cnt++;
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL setp_drained: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_prio();
      logic [31:0] exp_prio;
      logic [3:0]  exp_id;
`ifdef IRQ_CTRL_PRIO_EN
      exp_prio = 32'h000C_0001;
      exp_id   = 4'd9;
`else
      exp_prio = 32'h0;
      exp_id   = 4'd0;
`endif
      csr_write(A_EN, 32'h201);
      csr_write(A_PRIO, 32'h000C_0001);
      csr_read(A_PRIO, rd);
      total_cnt++;
      if (rd !== exp_prio) $display("FAIL prio_read: got %h expected %h", rd, exp_prio);
      else pass_cnt++;
      irq_src = 10'h201;
      tick();
      irq_src = 10'h000;
      tick();
      tick();
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h201) $display("FAIL prio_pend: got %h expected %h", rd, 32'h201);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b1 || irq_id !== exp_id) $display("FAIL prio_winner: got %b/%0d expected 1/%0d", irq_valid, irq_id, exp_id);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (irq_cause !== 32'h8000_0010) $display("FAIL midrst_cause: got %h expected %h", irq_cause, 32'h8000_0010);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0 || irq_id !== 4'd0) $display("FAIL midrst_valid: got %b/%0d expected 0/0", irq_valid, irq_id);
      else pass_cnt++;
      rst_n = 1'b1;
      csr_read(A_PEND, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL midrst_pend: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      csr_read(A_MODE, rd);
      total_cnt++;
      if (rd !== 32'h3FF) $display("FAIL midrst_mode: got %h expected %h", rd, 32'h3FF);
      else pass_cnt++;
      csr_read(A_EN, rd);
      total_cnt++;
      if (rd !== 32'h0) $display("FAIL midrst_en: got %h expected %h", rd, 32'h0);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (irq_valid !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", irq_valid);
      else pass_cnt++;
   endtask

   initial begin
      rst_n       = 1'b0;
      irq_src     = '0;
      csr_rd_en   = 1'b0;
      csr_wr_en   = 1'b0;
      csr_addr    = '0;
      csr_wr_data = '0;
      global_mie  = 1'b0;
      irq_ack     = 1'b0;
      test_reset();
      test_edge();
      test_csr_and_ack_ignore();
      test_arbitration();
      test_level();
      test_set_priority();
      test_prio();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
